// File: rtl/ysyx_23060332_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   - ARB_* : arbiter FSM state encodings
//   - OWN_* : owner register encodings (which requester holds the port)
//   - GNT_* : bit positions inside the picker grant vector
//   - DEF_* : default address / data widths
package ysyx_23060332_mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

endpackage

// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// Bundle of every handshake/bus signal around the memory arbiter.
//   ifu_* : instruction fetch requester (read-only)
//   lsu_* : load/store requester (read/write)
//   mem_* : downstream memory / bus bridge port
// Modports:
//   slave  : arbiter view (takes requests from IFU/LSU, drives mem_*)
//   master : environment view (requesters plus downstream memory)
interface ysyx_23060332_mem_arbiter_if
  import ysyx_23060332_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_W-1:0]     ifu_addr;
  logic                  ifu_rsp_valid;
  logic [DATA_W-1:0]     ifu_rdata;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_W-1:0]     lsu_addr;
  logic                  lsu_wen;
  logic [DATA_W-1:0]     lsu_wdata;
  logic [DATA_W/8-1:0]   lsu_wmask;
  logic                  lsu_rsp_valid;
  logic [DATA_W-1:0]     lsu_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_23060332_arb_pick.sv
// Combinational 2-way picker for the memory arbiter.
// Ports:
//   ifu_valid : IFU request pending
//   lsu_valid : LSU request pending
//   rr_last   : owner granted last time (only meaningful in round-robin mode)
//   grant     : one-hot grant, bit GNT_IFU / GNT_LSU; zero when nothing pends
// Build option YSYX_23060332_ARB_RR_EN: when defined, a tie goes to the
// requester that was not granted last; otherwise the LSU always wins a tie.
// A lone request is granted in either mode.
module ysyx_23060332_arb_pick
  import ysyx_23060332_mem_arbiter_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  logic       rr_last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
`ifdef YSYX_23060332_ARB_RR_EN
      if (rr_last == OWN_LSU) grant[GNT_IFU] = 1'b1;
      else                    grant[GNT_LSU] = 1'b1;
`else
      grant[GNT_LSU] = 1'b1;
`endif
    end else if (lsu_valid) begin
      grant[GNT_LSU] = 1'b1;
    end else if (ifu_valid) begin
      grant[GNT_IFU] = 1'b1;
    end
  end

`ifndef YSYX_23060332_ARB_RR_EN
  // Fixed priority ignores the history input.
  logic unused_rr_last;
  assign unused_rr_last = rr_last;
`endif

endmodule

// File: rtl/ysyx_23060332_mem_arbiter.sv
// Memory port arbiter between the IFU (fetch, read-only) and the LSU
// (load/store). One transaction outstanding at a time: a request is accepted
// in IDLE, registered, presented downstream in ISSUE, and the response is
// routed back to the owner in WAIT.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : ysyx_23060332_mem_arbiter_if.slave (ifu_*, lsu_*, mem_* groups)
// Build option YSYX_23060332_ARB_RR_EN: round-robin tie-break using rr_last;
// default build uses fixed LSU priority and has no rr_last register.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no transaction; accept winner, capture payload
// ARB_ISSUE | mem_req_valid high with registered payload until ready
// ARB_WAIT  | request taken downstream; wait for mem_rsp_valid
module ysyx_23060332_mem_arbiter
  import ysyx_23060332_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
)(
  input  logic                           clk,
  input  logic                           rst,
  ysyx_23060332_mem_arbiter_if.slave     bus
);

  arb_state_e            state;
  logic                  owner;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic                  mem_req_valid_q;
  logic                  rr_last;
  logic [1:0]            grant;
  logic                  accept_ok;
  logic                  rsp_fire;

  ysyx_23060332_arb_pick u_pick (
    .ifu_valid (bus.ifu_req_valid),
    .lsu_valid (bus.lsu_req_valid),
    .rr_last   (rr_last),
    .grant     (grant)
  );

  // Reset wins over acceptance and response: nothing is handed out in a
  // reset cycle, so the outstanding transaction is silently dropped.
  assign accept_ok = (state == ARB_IDLE) && !rst;
  assign rsp_fire  = (state == ARB_WAIT) && bus.mem_rsp_valid && !rst;

  assign bus.ifu_req_ready = accept_ok && grant[GNT_IFU];
  assign bus.lsu_req_ready = accept_ok && grant[GNT_LSU];

  assign bus.ifu_rsp_valid = rsp_fire && (owner == OWN_IFU);
  assign bus.lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
  assign bus.ifu_rdata     = bus.ifu_rsp_valid ? bus.mem_rdata : '0;
  assign bus.lsu_rdata     = bus.lsu_rsp_valid ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ARB_IDLE;
      owner           <= OWN_IFU;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      mem_req_valid_q <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant[GNT_LSU]) begin
            owner           <= OWN_LSU;
            addr_q          <= bus.lsu_addr;
            wen_q           <= bus.lsu_wen;
            wdata_q         <= bus.lsu_wdata;
            wmask_q         <= bus.lsu_wmask;
            mem_req_valid_q <= 1'b1;
            state           <= ARB_ISSUE;
          end else if (grant[GNT_IFU]) begin
            // Fetches are always reads with an empty mask.
            owner           <= OWN_IFU;
            addr_q          <= bus.ifu_addr;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b1;
            state           <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (bus.mem_rsp_valid) state <= ARB_IDLE;
        end
        default: begin
          mem_req_valid_q <= 1'b0;
          state           <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef YSYX_23060332_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)                  rr_last <= OWN_IFU;
    else if (accept_ok && (grant != 2'b00))
                              rr_last <= grant[GNT_LSU] ? OWN_LSU : OWN_IFU;
  end
`else
  assign rr_last = OWN_IFU;
`endif

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
module tb_ysyx_23060332_mem_arbiter;
  import ysyx_23060332_mem_arbiter_pkg::*;

`ifdef YSYX_23060332_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    logic        own;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  logic model_last = OWN_IFU;
  txn_t sb[$];

  always #5 clk = ~clk;

  ysyx_23060332_mem_arbiter_if bus ();

  ysyx_23060332_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic own, input logic [31:0] addr, input logic wen,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              input logic [31:0] rdata);
    txn_t t;
    t.own = own; t.addr = addr; t.wen = wen;
    t.wdata = wdata; t.wmask = wmask; t.rdata = rdata;
    return t;
  endfunction

  task automatic drive_ifu(input logic [31:0] a);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = a;
  endtask

  task automatic drive_lsu(input logic [31:0] a, input logic wen,
                           input logic [31:0] wd, input logic [3:0] wm);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = a;
    bus.lsu_wen       = wen;
    bus.lsu_wdata     = wd;
    bus.lsu_wmask     = wm;
  endtask

  // Tie-break reference: fixed LSU priority, or "not the one granted last".
  task automatic push_pair(input txn_t ti, input txn_t tl);
    if (!RR_EN || model_last == OWN_IFU) begin
      sb.push_back(tl); sb.push_back(ti);
    end else begin
      sb.push_back(ti); sb.push_back(tl);
    end
  endtask

  // Accept cycle through ISSUE; returns with the DUT in WAIT.
  task automatic issue_phase(input int rdy_dly, input bit spur, output txn_t t);
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: observed 0 entries, expected >0");
      $fatal(1, "scoreboard underflow");
    end
    t = sb.pop_front();
    #1;
    if (t.own == OWN_LSU) begin
      chk("lsu_ready_grant", bus.lsu_req_ready, 1);
      chk("ifu_ready_lose",  bus.ifu_req_ready, 0);
    end else begin
      chk("ifu_ready_grant", bus.ifu_req_ready, 1);
      chk("lsu_ready_lose",  bus.lsu_req_ready, 0);
    end
    model_last = t.own;
    tick();
    if (t.own == OWN_LSU) bus.lsu_req_valid = 1'b0;
    else                  bus.ifu_req_valid = 1'b0;
    for (int i = 0; i <= rdy_dly; i++) begin
      bus.mem_rsp_valid = spur && (i < rdy_dly);
      bus.mem_rdata     = (spur && (i < rdy_dly)) ? 32'hBAD0_0BAD : 32'h0;
      bus.mem_req_ready = (i == rdy_dly);
      #1;
      chk("mem_req_valid", bus.mem_req_valid, 1);
      chk("mem_addr",      bus.mem_addr,  t.addr);
      chk("mem_wen",       bus.mem_wen,   t.wen);
      chk("mem_wdata",     bus.mem_wdata, t.wdata);
      chk("mem_wmask",     bus.mem_wmask, t.wmask);
      chk("ifu_ready_busy", bus.ifu_req_ready, 0);
      chk("lsu_ready_busy", bus.lsu_req_ready, 0);
      if (spur) begin
        chk("spur_issue_ifu_rsp", bus.ifu_rsp_valid, 0);
        chk("spur_issue_lsu_rsp", bus.lsu_rsp_valid, 0);
      end
      tick();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
  endtask

  // WAIT through response pulse; returns with the DUT back in IDLE.
  task automatic rsp_phase(input txn_t t, input int rsp_dly);
    for (int i = 0; i < rsp_dly; i++) begin
      #1;
      chk("wait_mem_valid", bus.mem_req_valid, 0);
      chk("wait_ifu_rsp",   bus.ifu_rsp_valid, 0);
      chk("wait_lsu_rsp",   bus.lsu_rsp_valid, 0);
      tick();
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = t.rdata;
    #1;
    if (t.own == OWN_LSU) begin
      chk("lsu_rsp_valid", bus.lsu_rsp_valid, 1);
      chk("lsu_rdata",     bus.lsu_rdata, t.rdata);
      chk("ifu_rsp_other", bus.ifu_rsp_valid, 0);
      chk("ifu_rdata_zero", bus.ifu_rdata, 0);
    end else begin
      chk("ifu_rsp_valid", bus.ifu_rsp_valid, 1);
      chk("ifu_rdata",     bus.ifu_rdata, t.rdata);
      chk("lsu_rsp_other", bus.lsu_rsp_valid, 0);
      chk("lsu_rdata_zero", bus.lsu_rdata, 0);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    #1;
    chk("ifu_rsp_pulse_end", bus.ifu_rsp_valid, 0);
    chk("lsu_rsp_pulse_end", bus.lsu_rsp_valid, 0);
    chk("idle_mem_valid",    bus.mem_req_valid, 0);
  endtask

  task automatic serve(input int rdy_dly, input int rsp_dly, input bit spur);
    txn_t t;
    issue_phase(rdy_dly, spur, t);
    rsp_phase(t, rsp_dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr  = 32'h0;
    bus.lsu_req_valid = 1'b0; bus.lsu_addr  = 32'h0;
    bus.lsu_wen = 1'b0; bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'h0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'h0;

    // Reset: readies stay low even with a request pending.
    rst = 1'b1;
    tick(); tick();
    drive_ifu(32'h8000_0000);
    #1;
    chk("rst_ifu_ready", bus.ifu_req_ready, 0);
    chk("rst_lsu_ready", bus.lsu_req_ready, 0);
    bus.ifu_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_mem_wen",   bus.mem_wen, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_ifu_rsp",   bus.ifu_rsp_valid, 0);
    chk("rst_lsu_rsp",   bus.lsu_rsp_valid, 0);
    tick();

    // IFU read, 1-cycle ready, data two cycles later.
    drive_ifu(32'h8000_0000);
    sb.push_back(mk(OWN_IFU, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413));
    serve(0, 1, 1'b0);

    // LSU store.
    drive_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    sb.push_back(mk(OWN_LSU, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0));
    serve(1, 0, 1'b0);

    // Two simultaneous pairs; loser waits for the next transaction.
    for (int p = 0; p < 2; p++) begin
      drive_ifu(32'h8000_0004 + 32'(p * 4));
      drive_lsu(32'h8000_2000 + 32'(p * 4), 1'b0, 32'h0, 4'h0);
      push_pair(mk(OWN_IFU, 32'h8000_0004 + 32'(p * 4), 1'b0, 32'h0, 4'h0,
                   32'h0000_0013 + 32'(p)),
                mk(OWN_LSU, 32'h8000_2000 + 32'(p * 4), 1'b0, 32'h0, 4'h0,
                   32'h1111_2222 + 32'(p)));
      serve(0, 1, 1'b0);
      serve(0, 0, 1'b0);
    end

    // Downstream backpressure for 5 cycles.
    drive_lsu(32'h8000_4000, 1'b1, 32'h0123_4567, 4'h3);
    sb.push_back(mk(OWN_LSU, 32'h8000_4000, 1'b1, 32'h0123_4567, 4'h3, 32'hCAFE_F00D));
    serve(5, 2, 1'b0);

    // Spurious response while IDLE, then while ISSUE.
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h5555_AAAA;
    #1;
    chk("spur_idle_ifu_rsp", bus.ifu_rsp_valid, 0);
    chk("spur_idle_lsu_rsp", bus.lsu_rsp_valid, 0);
    chk("spur_idle_ifu_rdata", bus.ifu_rdata, 0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("spur_idle_state", bus.mem_req_valid, 0);
    drive_ifu(32'h8000_0010);
    sb.push_back(mk(OWN_IFU, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 32'h0000_0067));
    serve(2, 1, 1'b1);

    // Reset while WAIT with a response arriving in the same cycle.
    drive_lsu(32'h8000_3000, 1'b1, 32'hA5A5_5A5A, 4'hC);
    sb.push_back(mk(OWN_LSU, 32'h8000_3000, 1'b1, 32'hA5A5_5A5A, 4'hC, 32'h0));
    issue_phase(0, 1'b0, t);
    rst = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1234_5678;
    #1;
    chk("rstw_lsu_rsp", bus.lsu_rsp_valid, 0);
    chk("rstw_ifu_rsp", bus.ifu_rsp_valid, 0);
    tick();
    rst = 1'b0;
    model_last = OWN_IFU;
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("rstw_mem_valid", bus.mem_req_valid, 0);
    chk("rstw_mem_addr",  bus.mem_addr, 0);
    chk("rstw_mem_wen",   bus.mem_wen, 0);
    chk("rstw_mem_wdata", bus.mem_wdata, 0);
    chk("rstw_mem_wmask", bus.mem_wmask, 0);
    chk("rstw_lsu_ready", bus.lsu_req_ready, 0);
    bus.mem_rsp_valid = 1'b1;
    #1;
    chk("rstw_late_lsu_rsp", bus.lsu_rsp_valid, 0);
    chk("rstw_late_ifu_rsp", bus.ifu_rsp_valid, 0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    #1;
    chk("rstw_idle", bus.mem_req_valid, 0);

    // Recovery: a plain fetch after the aborted store.
    drive_ifu(32'h8000_0020);
    sb.push_back(mk(OWN_IFU, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 32'h0010_0073));
    serve(0, 0, 1'b0);

    chk("sb_drained", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_mem_arbiter.md
Name: ysyx_23060332_mem_arbiter

Overview:
- Shares one memory port between the instruction fetch requester (IFU, read-only) and the load/store requester (LSU, read/write) of the multi-cycle core.
- Sits between the IFU/LSU and the memory/bus bridge.
- Accepts one request at a time, registers it, and issues it downstream.
- Waits for the response and routes it back to the owning requester; at most one transaction is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte mask width is DATA_W/8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  access address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  store byte mask.
- lsu_rsp_valid  out  1  access complete, one-cycle pulse, asserted for loads and stores.
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  downstream request.
- mem_req_ready  in  1  downstream accepts request.
- mem_addr  out  ADDR_W  downstream address.
- mem_wen  out  1  downstream write enable.
- mem_wdata  out  DATA_W  downstream write data.
- mem_wmask  out  DATA_W/8  downstream byte mask.
- mem_rsp_valid  in  1  downstream response.
- mem_rdata  in  DATA_W  downstream read data.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- FSM states are IDLE, ISSUE and WAIT. A 1-bit owner register records the granted requester (0 = IFU, 1 = LSU).
- Reset: state = IDLE, owner = 0, all request registers = 0, rr_last = 0.
  - All *_ready, *_rsp_valid and mem_req_valid outputs are 0.
  - All data/address outputs are 0.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner. Fixed priority: LSU wins over IFU.
  - winner_req_ready = 1 for exactly this cycle, combinationally. The loser's ready = 0.
  - Winner's addr/wen/wdata/wmask are captured into registers; IFU forces wen = 0 and wmask = 0.
  - Owner is set and the FSM goes to ISSUE.
  - No requests: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1; mem_* outputs are driven from the registers and are stable while valid is high.
  - On mem_req_ready = 1 the FSM goes to WAIT.
  - Valid is never withdrawn before ready.
- WAIT:
  - On mem_rsp_valid = 1: owner_rsp_valid = 1 and owner_rdata = mem_rdata, combinationally in the same cycle. Then go to IDLE.
  - The non-owner's rsp_valid stays 0.
- mem_rsp_valid outside WAIT is ignored and produces no response pulse.
- ifu_rdata and lsu_rdata equal mem_rdata whenever their rsp_valid is high; otherwise they are 0.
- Latency: accept to mem_req_valid is 1 cycle. mem_rsp_valid to requester rsp_valid is 0 cycles.
- Back-to-back throughput: one transaction per (3 + downstream wait) cycles. A new accept is only possible in the cycle after the response.
- The *_req_ready outputs are 0 in ISSUE and WAIT. Requesters must hold valid and payload until ready.
- Simultaneous IFU and LSU requests in IDLE: LSU is granted; IFU stays pending and is granted in the next IDLE cycle unless the LSU requests again.
- Reset in ISSUE or WAIT:
  - The FSM returns to IDLE and the outstanding transaction is dropped; no rsp_valid is generated.
  - The downstream memory must be reset in the same cycle.

Optional Feature:
- Macro: YSYX_23060332_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using register rr_last, updated on every grant to the granted requester.
  - On a simultaneous request, the requester not granted last wins.
  - Single requests are granted regardless of rr_last.
- Undefined:
  - Fixed LSU priority; rr_last is not implemented.

Decomposition:
- Shared package/define file (the existing ysyx_23060332_define set):
  - FSM state encodings ARB_IDLE = 2'd0, ARB_ISSUE = 2'd1, ARB_WAIT = 2'd2.
  - Owner encodings OWN_IFU = 1'b0, OWN_LSU = 1'b1.
  - Default address/data widths.
- Sub-module: ysyx_23060332_arb_pick, the combinational 2-way priority/round-robin picker.
  - Inputs: the two request valids and rr_last.
  - Outputs: grant vector.
- FSM, request registers and response routing stay in the top arbiter.

Test Plan:
- Reset then IFU read:
  - Stimulus: ifu_addr = 0x80000000; memory has 1-cycle ready and returns 0x00000413 two cycles later.
  - Response: ifu_req_ready pulses once; mem_req_valid is high the next cycle with addr 0x80000000, wen = 0; ifu_rsp_valid pulses with rdata 0x00000413; lsu_rsp_valid stays 0.
- LSU store:
  - Stimulus: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF.
  - Response: mem_* carry exactly these values with mem_wen = 1; lsu_rsp_valid pulses once on mem_rsp_valid.
- Simultaneous requests:
  - Stimulus: IFU 0x80000004 and LSU load 0x80002000 in the same cycle.
  - Response: LSU issued first. IFU is issued in the next transaction, with ifu_req_ready held at 0 until then. With YSYX_23060332_ARB_RR_EN and a second simultaneous pair, IFU goes first.
- Downstream backpressure:
  - Stimulus: mem_req_ready held low 5 cycles.
  - Response: mem_req_valid and payload are stable for all 5 cycles; both requester readies are 0.
- Spurious response:
  - Stimulus: mem_rsp_valid = 1 while IDLE or ISSUE.
  - Response: no rsp_valid pulse on either side; state unchanged.
- Reset mid-transaction:
  - Stimulus: rst asserted in WAIT.
  - Response: next cycle state is IDLE and all outputs are 0; a later mem_rsp_valid produces no pulse.
